seq_detector_prog: RTL

- Runtime-programmable serial bit-pattern detector; generalises the fixed 4-bit "1011" detector.
- Pattern length is configurable up to MAX_LEN bits, with overlapping or non-overlapping match mode.
- Has an input-valid qualifier and a registered match pulse.
- Sits on a serial bit stream (line decoder / frame-sync front end); a local control block configures it.

---
 rtl/seq_detector_prog.sv | 122 ++++++++++++
 1 files changed

// File: rtl/seq_detector_prog.sv
// Runtime-programmable serial bit-pattern detector (length, pattern, overlap mode).
// Optional match counter built only when SEQ_DET_MATCH_COUNT_EN is defined.
module seq_detector_prog #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = 4,
  parameter int CNT_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  input  logic               in_valid,
  input  logic               in,
  input  logic               cnt_clr,
  output logic               match,
  output logic [CNT_W-1:0]   match_count,
  output logic               armed
);

  localparam logic [0:0] FILL  = 1'b0;
  localparam logic [0:0] ARMED = 1'b1;

  localparam logic [MAX_LEN-1:0] DEF_PATTERN = MAX_LEN'(4'b1011);
  localparam logic [LEN_W-1:0]   DEF_LEN     = LEN_W'(4);
  localparam logic [LEN_W-1:0]   LEN_MAX     = LEN_W'(MAX_LEN);

  logic [MAX_LEN-1:0] pattern_reg;
  logic [LEN_W-1:0]   len_reg;
  logic               overlap_reg;

  // Only MAX_LEN-1 past bits are ever compared; the incoming bit completes the window.
  logic [MAX_LEN-2:0] hist_reg;
  logic [LEN_W-1:0]   fill_reg;
  logic [0:0]         state_reg;
  logic               match_reg;

  logic [MAX_LEN-1:0] window;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   fill_next;
  logic [LEN_W-1:0]   len_clamped;
  logic               len_nonzero;
  logic               pattern_eq;
  logic               bit_accept;
  logic               hit_now;
  logic               full_next;

  assign window      = {hist_reg, in};
  assign len_nonzero = (len_reg != '0);
  assign len_clamped = (cfg_len > LEN_MAX) ? LEN_MAX : cfg_len;

  generate
    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_mask
      assign mask[gi] = (len_reg > LEN_W'(gi));
    end
  endgenerate

  assign pattern_eq = (((window ^ pattern_reg) & mask) == '0);
  assign fill_next  = (fill_reg < len_reg) ? (fill_reg + LEN_W'(1)) : fill_reg;
  assign full_next  = len_nonzero && (fill_next == len_reg);
  // A new configuration discards any bit arriving in the same cycle.
  assign bit_accept = in_valid && !cfg_load;
  assign hit_now    = bit_accept && full_next && pattern_eq;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pattern_reg <= DEF_PATTERN;
      len_reg     <= DEF_LEN;
      overlap_reg <= 1'b1;
      hist_reg    <= '0;
      fill_reg    <= '0;
      state_reg   <= FILL;
      match_reg   <= 1'b0;
    end else if (cfg_load) begin
      pattern_reg <= cfg_pattern;
      len_reg     <= len_clamped;
      overlap_reg <= cfg_overlap;
      hist_reg    <= '0;
      fill_reg    <= '0;
      state_reg   <= FILL;
      match_reg   <= 1'b0;
    end else if (in_valid) begin
      hist_reg  <= window[MAX_LEN-2:0];
      match_reg <= hit_now;
      if (hit_now && !overlap_reg) begin
        fill_reg  <= '0;
        state_reg <= FILL;
      end else begin
        fill_reg  <= fill_next;
        state_reg <= full_next ? ARMED : FILL;
      end
    end else begin
      match_reg <= 1'b0;
    end
  end

  assign match = match_reg;
  assign armed = (state_reg == ARMED);

`ifdef SEQ_DET_MATCH_COUNT_EN
  logic [CNT_W-1:0] count_reg;

  // Clear wins over a coincident match; the count saturates at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (cnt_clr) begin
      count_reg <= '0;
    end else if (hit_now && (count_reg != {CNT_W{1'b1}})) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign match_count = count_reg;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign match_count    = '0;
`endif

endmodule
